down_counter_timer: RTL and testbench

Loadable down-counting timer: the counterpart to the free-running up counter. Software or a control FSM loads a start value, the block decrements once per enabled cycle, and it flags expiry with a single-cycle terminal-count pulse. It supports one-shot and auto-reload (periodic tick) modes, abort, and restart. It sits beside the existing up counter in the timing/control layer and drives timeouts and periodic strobes.

---
 rtl/down_counter_timer.sv | 98 +++++++++
 tb/tb_down_counter_timer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes, abort and restart.
// Emits a one-cycle terminal-count pulse on the cycle after count was 1.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] rld_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             start_ok;

  assign start_ok = start && (start_val != ZERO);

  // Next-state and next-output decode: abort beats start beats the count step.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    rld_nxt   = rld;
    tc_nxt    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      count_nxt = ZERO;
    end else if (start_ok) begin
      state_nxt = RUN;
      count_nxt = start_val;
      rld_nxt   = start_val;
    end else begin
      case (state)
        IDLE: begin
          count_nxt = count;
        end
        RUN: begin
          if (!en) begin
            count_nxt = count;
          end else if (count == ONE) begin
            tc_nxt = 1'b1;
            if (auto_reload) begin
              count_nxt = rld;
            end else begin
              count_nxt = ZERO;
              state_nxt = IDLE;
            end
          end else if (count > ONE) begin
            count_nxt = count - ONE;
          end else begin
            // A zero count in RUN is unreachable; recover to IDLE rather than wrap.
            count_nxt = ZERO;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = ZERO;
        end
      endcase
    end
  end

  // State, reload and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rld   <= ZERO;
      count <= ZERO;
      busy  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      rld   <= rld_nxt;
      count <= count_nxt;
      busy  <= (state_nxt == RUN);
      tc    <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer (WIDTH=4): each step drives inputs,
// advances one clock edge and checks {count, busy, tc} against hand-computed values.
module tb_down_counter_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] start_val;
  logic       en;
  logic       auto_reload;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       tc;

  int vectors;
  int miscompares;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_val   (start_val),
    .en          (en),
    .auto_reload (auto_reload),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .tc          (tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] c, input logic b, input logic t);
    vectors++;
    assert ({count, busy, tc} === {c, b, t})
    else begin
      miscompares++;
      $error("FAIL %s: observed count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
             tag, count, busy, tc, c, b, t);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    start_val   = 4'd0;
    en          = 1'b0;
    auto_reload = 1'b0;
    abort       = 1'b0;

    #12;
    chk("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 4'd0, 1'b0, 1'b0);

    // One-shot, start_val=4
    start = 1'b1; start_val = 4'd4; en = 1'b1; auto_reload = 1'b0;
    tick(); chk("os_load", 4'd4, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk("os_3", 4'd3, 1'b1, 1'b0);
    tick(); chk("os_2", 4'd2, 1'b1, 1'b0);
    tick(); chk("os_1", 4'd1, 1'b1, 1'b0);
    tick(); chk("os_expire", 4'd0, 1'b0, 1'b1);
    tick(); chk("os_idle", 4'd0, 1'b0, 1'b0);

    // start_val=0 in IDLE is ignored
    start = 1'b1; start_val = 4'd0;
    tick(); chk("zero_start_idle", 4'd0, 1'b0, 1'b0);
    start = 1'b0;

    // Auto-reload with a two-cycle pause at count=2
    start = 1'b1; start_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
    tick(); chk("ar_load", 4'd3, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk("ar_2", 4'd2, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk("ar_pause1", 4'd2, 1'b1, 1'b0);
    tick(); chk("ar_pause2", 4'd2, 1'b1, 1'b0);
    en = 1'b1;
    tick(); chk("ar_1", 4'd1, 1'b1, 1'b0);
    tick(); chk("ar_reload1", 4'd3, 1'b1, 1'b1);
    tick(); chk("ar_2b", 4'd2, 1'b1, 1'b0);
    tick(); chk("ar_1b", 4'd1, 1'b1, 1'b0);
    tick(); chk("ar_reload2", 4'd3, 1'b1, 1'b1);
    start = 1'b1; start_val = 4'd0;
    tick(); chk("zero_start_run", 4'd2, 1'b1, 1'b0);
    start = 1'b0; abort = 1'b1;
    tick(); chk("abort_run", 4'd0, 1'b0, 1'b0);
    abort = 1'b0;

    // start_val=1 in auto-reload: tc every enabled cycle
    start = 1'b1; start_val = 4'd1; auto_reload = 1'b1; en = 1'b1;
    tick(); chk("sv1_load", 4'd1, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sv1_tick", 4'd1, 1'b1, 1'b1);
    end
    en = 1'b0;
    tick(); chk("sv1_pause", 4'd1, 1'b1, 1'b0);
    en = 1'b1; auto_reload = 1'b0;
    tick(); chk("sv1_oneshot_end", 4'd0, 1'b0, 1'b1);
    tick(); chk("sv1_idle", 4'd0, 1'b0, 1'b0);

    // Abort coincident with expiry: no tc
    start = 1'b1; start_val = 4'd2;
    tick(); chk("abx_load", 4'd2, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk("abx_1", 4'd1, 1'b1, 1'b0);
    abort = 1'b1;
    tick(); chk("abx_abort", 4'd0, 1'b0, 1'b0);
    abort = 1'b0;
    tick(); chk("abx_after", 4'd0, 1'b0, 1'b0);

    // Start coincident with expiry: start wins
    start = 1'b1; start_val = 4'd2;
    tick(); chk("stx_load", 4'd2, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk("stx_1", 4'd1, 1'b1, 1'b0);
    start = 1'b1; start_val = 4'd6;
    tick(); chk("stx_restart", 4'd6, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk("stx_5", 4'd5, 1'b1, 1'b0);

    // Restart with 9 at count=5
    start = 1'b1; start_val = 4'd9;
    tick(); chk("rs_load", 4'd9, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      tick(); chk("rs_count", 4'(i), 1'b1, 1'b0);
    end
    tick(); chk("rs_expire", 4'd0, 1'b0, 1'b1);

    // Full range: start_val=15
    start = 1'b1; start_val = 4'd15;
    tick(); chk("full_load", 4'd15, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 14; i >= 1; i--) begin
      tick(); chk("full_count", 4'(i), 1'b1, 1'b0);
    end
    tick(); chk("full_expire", 4'd0, 1'b0, 1'b1);

    // Start loads even with en=0, then async reset mid-cycle at count=5
    en = 1'b0; start = 1'b1; start_val = 4'd5;
    tick(); chk("en0_load", 4'd5, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk("en0_hold", 4'd5, 1'b1, 1'b0);
    en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 4'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    tick(); chk("post_reset1", 4'd0, 1'b0, 1'b0);
    tick(); chk("post_reset2", 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
